// File: rtl/ysyx_24110006_trap_ctrl.sv
// Trap/CSR sequencing stage. It accepts one system-class instruction, issues a single CSR-file
// strobe, and returns the next PC. Optional timer-interrupt take is enabled by `TRAP_IRQ_EN.
module ysyx_24110006_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic        i_is_csrw,
  input  logic        i_is_ecall,
  input  logic        i_is_mret,
  input  logic        i_is_illegal,
  input  logic [11:0] i_csr,
  input  logic [31:0] i_wdata,
  input  logic        i_irq,
  input  logic        i_mie,
  output logic        o_csr_valid,
  output logic        o_csr_wen,
  output logic [2:0]  o_csr_t,
  output logic [11:0] o_csr,
  output logic [31:0] o_csr_pc,
  output logic [31:0] o_csr_wdata,
  output logic [31:0] o_mcause,
  input  logic [31:0] i_csr_rdata,
  input  logic [31:0] i_csr_upc,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_redirect,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // A producer holds its payload stable while valid is high and ready is low.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] C_PLAIN = 2'd0;
  localparam logic [1:0] C_CSRW  = 2'd1;
  localparam logic [1:0] C_MRET  = 2'd2;
  localparam logic [1:0] C_TRAP  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  cls_q;
  logic [31:0] pc_q;
  logic [11:0] csr_q;
  logic [31:0] wdata_q;
  logic [31:0] cause_q;
  logic [1:0]  cls_d;
  logic [31:0] cause_d;
  logic        irq_take;
  logic        issue;

`ifdef TRAP_IRQ_EN
  assign irq_take = i_irq & i_mie;
`else
  logic unused_irq;
  assign irq_take   = 1'b0;
  assign unused_irq = i_irq ^ i_mie;
`endif

  // Classification is resolved at acceptance, so ISSUE only has to look at cls_q.
  always_comb begin
    cls_d   = C_PLAIN;
    cause_d = 32'h0;
    if (irq_take) begin
      cls_d   = C_TRAP;
      cause_d = 32'h8000_0007;
    end else if (i_is_illegal) begin
      cls_d   = C_TRAP;
      cause_d = 32'h0000_0002;
    end else if (i_is_ecall) begin
      cls_d   = C_TRAP;
      cause_d = 32'h0000_000b;
    end else if (i_is_mret) begin
      cls_d = C_MRET;
    end else if (i_is_csrw) begin
      cls_d = C_CSRW;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      cls_q      <= C_PLAIN;
      pc_q       <= 32'h0;
      csr_q      <= 12'h0;
      wdata_q    <= 32'h0;
      cause_q    <= 32'h0;
      o_redirect <= 1'b0;
      o_next_pc  <= RESET_PC;
      o_rdata    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            cls_q   <= cls_d;
            pc_q    <= i_pc;
            csr_q   <= i_csr;
            wdata_q <= i_wdata;
            cause_q <= cause_d;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (cls_q)
            C_TRAP, C_MRET: begin
              o_next_pc  <= i_csr_upc;
              o_redirect <= 1'b1;
              o_rdata    <= 32'h0;
            end
            C_CSRW: begin
              o_next_pc  <= pc_q + 32'd4;
              o_redirect <= 1'b0;
              o_rdata    <= i_csr_rdata;
            end
            default: begin
              o_next_pc  <= pc_q + 32'd4;
              o_redirect <= 1'b0;
              o_rdata    <= 32'h0;
            end
          endcase
          state <= S_RESP;
        end
        S_RESP: begin
          if (i_out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign issue       = (state == S_ISSUE);
  assign o_ready     = (state == S_IDLE);
  assign o_out_valid = (state == S_RESP);
  assign o_csr_valid = issue;
  assign o_csr_wen   = issue & ((cls_q == C_TRAP) | (cls_q == C_CSRW));
  assign o_csr       = csr_q;
  assign o_csr_pc    = pc_q;
  assign o_csr_wdata = wdata_q;
  assign o_mcause    = cause_q;
  assign o_state     = state;

  always_comb begin
    o_csr_t = 3'b111;
    if (issue) begin
      case (cls_q)
        C_TRAP:  o_csr_t = 3'b011;
        C_CSRW:  o_csr_t = 3'b001;
        C_MRET:  o_csr_t = 3'b000;
        default: o_csr_t = 3'b111;
      endcase
    end
  end

endmodule
